// File: rtl/bus_xbar_pkg.sv
// Shared types and default SoC address map for the bus_xbar interconnect.
// The default map has two slaves: block RAM at 0x4000-0x5FFF and device/MMIO at 0x7000-0x7FFF.
package bus_xbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } xbar_state_t;

  localparam logic [15:0] BRAM_BASE = 16'h4000;
  localparam logic [15:0] BRAM_MASK = 16'hE000;
  localparam logic [15:0] DEV_BASE  = 16'h7000;
  localparam logic [15:0] DEV_MASK  = 16'hF000;

  // Wide enough for any TIMEOUT in 1..255.
  localparam int CNT_W = 8;

endpackage

// File: rtl/bus_xbar_decode.sv
// Combinational base/mask address decoder.
// Produces a one-hot hit vector in which the lowest matching slave index wins, plus a miss flag.
module xbar_decode
  import bus_xbar_pkg::*;
#(
  parameter int                   N_SLV = 2,
  parameter int                   AW    = 16,
  parameter logic [N_SLV*AW-1:0]  BASE  = {DEV_BASE, BRAM_BASE},
  parameter logic [N_SLV*AW-1:0]  MASK  = {DEV_MASK, BRAM_MASK}
) (
  input  logic [AW-1:0]    addr,
  output logic [N_SLV-1:0] hit,
  output logic             miss
);

  always_comb begin
    hit  = '0;
    miss = 1'b1;
    for (int i = 0; i < N_SLV; i++) begin
      if (miss && ((addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW])) begin
        hit[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_xbar.sv
// 1-master / N-slave bus interconnect with req/ack wait states, decode-miss and timeout
// error responses, and a sticky capture of the first error address.
module bus_xbar
  import bus_xbar_pkg::*;
#(
  parameter int                   N_SLV   = 2,
  parameter int                   AW      = 16,
  parameter int                   DW      = 16,
  parameter logic [N_SLV*AW-1:0]  BASE    = {DEV_BASE, BRAM_BASE},
  parameter logic [N_SLV*AW-1:0]  MASK    = {DEV_MASK, BRAM_MASK},
  parameter int                   TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m_req,
  input  logic [AW-1:0]       m_addr,
  input  logic [DW-1:0]       m_wdata,
  input  logic                m_wen,
  output logic                m_ready,
  output logic [DW-1:0]       m_rdata,
  output logic                m_err,
  output logic [N_SLV-1:0]    s_req,
  output logic [AW-1:0]       s_addr,
  output logic [DW-1:0]       s_wdata,
  output logic                s_wen,
  input  logic [N_SLV-1:0]    s_ack,
  input  logic [N_SLV*DW-1:0] s_rdata,
  output logic                err_valid,
  output logic [AW-1:0]       err_addr,
  input  logic                err_clr
);

  // state  | meaning
  // IDLE   | waiting for m_req; request fields and decode captured on accept
  // ACTIVE | one slave selected, counting cycles until ack or timeout
  // RESP   | m_ready pulse with captured data / error flag

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  xbar_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             wen_q;
  logic [N_SLV-1:0] s_req_q;
  logic [DW-1:0]    rdata_q;
  logic             err_q;
  logic             err_valid_q;
  logic [AW-1:0]    err_addr_q;

  logic [N_SLV-1:0] dec_hit;
  logic             dec_miss;
  logic             accept, done_ack, done_to, ack_hit;
  logic [DW-1:0]    ack_data;
  logic             err_set;
  logic [AW-1:0]    err_set_addr;

  xbar_decode #(
    .N_SLV (N_SLV),
    .AW    (AW),
    .BASE  (BASE),
    .MASK  (MASK)
  ) u_decode (
    .addr (m_addr),
    .hit  (dec_hit),
    .miss (dec_miss)
  );

  // Only the selected slave's ack and data matter; strays from other slaves are masked.
  always_comb begin
    ack_hit  = |(s_ack & s_req_q);
    ack_data = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (s_req_q[i]) ack_data = ack_data | s_rdata[i*DW +: DW];
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    done_ack = 1'b0;
    done_to  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          accept  = 1'b1;
          state_d = dec_miss ? ST_RESP : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (ack_hit) begin
          done_ack = 1'b1;
          state_d  = ST_RESP;
        end else if (cnt_q == TO_CNT) begin
          done_to = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_set      = (accept & dec_miss) | done_to;
  assign err_set_addr = accept ? m_addr : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      s_req_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= m_addr;
        wdata_q <= m_wdata;
        wen_q   <= m_wen;
        s_req_q <= dec_hit;
        cnt_q   <= CNT_W'(1);
        rdata_q <= '0;
        err_q   <= dec_miss;
      end else if (done_ack) begin
        s_req_q <= '0;
        cnt_q   <= '0;
        rdata_q <= wen_q ? '0 : ack_data;
        err_q   <= 1'b0;
      end else if (done_to) begin
        s_req_q <= '0;
        cnt_q   <= '0;
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (state_q == ST_ACTIVE) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // A clear in the same cycle as a new error wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (err_clr) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (err_set && !err_valid_q) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= err_set_addr;
    end
  end

  assign m_ready   = (state_q == ST_RESP);
  assign m_rdata   = m_ready ? rdata_q : '0;
  assign m_err     = m_ready & err_q;
  assign s_req     = s_req_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wen     = wen_q & (|s_req_q);
  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_xbar.sv
// Randomised scoreboard bench for bus_xbar: stimulus pushes expected responses, a monitor
// pops them on m_ready, and a slave responder checks what the interconnect presents to slaves.
module tb_bus_xbar;

  localparam int N_SLV   = 2;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

  logic                clk;
  logic                rst_n;
  logic                m_req;
  logic [AW-1:0]       m_addr;
  logic [DW-1:0]       m_wdata;
  logic                m_wen;
  logic                m_ready;
  logic [DW-1:0]       m_rdata;
  logic                m_err;
  logic [N_SLV-1:0]    s_req;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_wdata;
  logic                s_wen;
  logic [N_SLV-1:0]    s_ack;
  logic [N_SLV*DW-1:0] s_rdata;
  logic                err_valid;
  logic [AW-1:0]       err_addr;
  logic                err_clr;

  bus_xbar #(
    .N_SLV   (N_SLV),
    .AW      (AW),
    .DW      (DW),
    .BASE    ({16'h7000, 16'h4000}),
    .MASK    ({16'hF000, 16'hE000}),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_req     (m_req),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wen     (m_wen),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .m_err     (m_err),
    .s_req     (s_req),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wen     (s_wen),
    .s_ack     (s_ack),
    .s_rdata   (s_rdata),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference address map, slave order lowest index first.
  logic [15:0] ref_base [N_SLV] = '{16'h4000, 16'h7000};
  logic [15:0] ref_mask [N_SLV] = '{16'hE000, 16'hF000};

  function automatic logic [N_SLV-1:0] ref_sel(input logic [AW-1:0] a);
    for (int i = 0; i < N_SLV; i++)
      if ((a & ref_mask[i]) == ref_base[i]) return N_SLV'(1) << i;
    return '0;
  endfunction

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            start;
    logic          lv;
    logic [AW-1:0] la;
  } exp_t;

  exp_t sb[$];

  // Reference error log.
  logic          log_v = 1'b0;
  logic [AW-1:0] log_a = '0;

  // Current transaction as seen by the slave responder.
  int               slv_delay = 0;
  logic [DW-1:0]    slv_data  = '0;
  logic [N_SLV-1:0] exp_sel   = '0;
  logic [AW-1:0]    exp_addr  = '0;
  logic             exp_wen   = 1'b0;
  logic [DW-1:0]    exp_wdata = '0;
  int               exp_active = 0;

  // Monitor
  always @(negedge clk) begin
    if (rst_n && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_m_ready", 32'(m_ready), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("m_rdata", 32'(m_rdata), 32'(e.rdata));
        chk("m_err", 32'(m_err), 32'(e.err));
        chk("latency", 32'(cyc - e.start), 32'(e.lat));
        chk("err_valid", 32'(err_valid), 32'(e.lv));
        chk("err_addr", 32'(err_addr), 32'(e.la));
      end
    end
  end

  // Slave responder: acks the selected slave after slv_delay ACTIVE cycles, adds stray acks.
  int act_cnt = 0;
  initial begin
    s_ack   = '0;
    s_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      s_rdata = N_SLV*DW'($urandom);
      s_ack   = '0;
      if (!rst_n) begin
        act_cnt = 0;
      end else if (s_req != '0) begin
        act_cnt++;
        if (act_cnt == 1) begin
          chk("s_req", 32'(s_req), 32'(exp_sel));
          chk("s_addr", 32'(s_addr), 32'(exp_addr));
          chk("s_wen", 32'(s_wen), 32'(exp_wen));
          if (exp_wen) chk("s_wdata", 32'(s_wdata), 32'(exp_wdata));
        end
        if (act_cnt == slv_delay) begin
          s_ack = s_req;
          for (int i = 0; i < N_SLV; i++)
            if (s_req[i]) s_rdata[i*DW +: DW] = slv_data;
        end
        if ($urandom_range(0, 2) == 0) s_ack = s_ack | (N_SLV'($urandom) & ~s_req);
      end else begin
        if (act_cnt != 0) chk("s_req_cycles", 32'(act_cnt), 32'(exp_active));
        act_cnt = 0;
        if ($urandom_range(0, 3) == 0) s_ack = N_SLV'($urandom);
      end
    end
  end

  task automatic do_txn(input logic [AW-1:0] addr, input logic wen, input logic [DW-1:0] wdata,
                        input int delay, input logic [DW-1:0] sdata, input logic clr,
                        input logic b2b, input logic scramble);
    exp_t e;
    logic [N_SLV-1:0] sel;
    bit got;
    @(posedge clk);
    #1;
    if (!b2b) begin
      m_req  = 1'b0;
      m_addr = AW'($urandom);
      @(posedge clk);
      #1;
    end
    sel = ref_sel(addr);
    if (sel == '0) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 1; exp_active = 0;
    end else if (delay <= TIMEOUT) begin
      e.err = 1'b0; e.rdata = wen ? '0 : sdata; e.lat = delay + 1; exp_active = delay;
    end else begin
      e.err = 1'b1; e.rdata = '0; e.lat = TIMEOUT + 1; exp_active = TIMEOUT;
    end
    if (clr) begin
      log_v = 1'b0;
      log_a = '0;
    end
    if (e.err && !log_v && !(clr && sel == '0)) begin
      log_v = 1'b1;
      log_a = addr;
    end
    e.lv = log_v;
    e.la = log_a;
    e.start = cyc;
    slv_delay = delay;
    slv_data  = sdata;
    exp_sel   = sel;
    exp_addr  = addr;
    exp_wen   = wen;
    exp_wdata = wdata;
    sb.push_back(e);
    m_req   = 1'b1;
    m_addr  = addr;
    m_wdata = wdata;
    m_wen   = wen;
    err_clr = clr;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    if (scramble) begin
      m_addr  = AW'($urandom);
      m_wdata = DW'($urandom);
      m_wen   = ~m_wen;
    end
    got = 0;
    for (int k = 0; k < TIMEOUT + 10; k++) begin
      @(negedge clk);
      if (m_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("m_ready_wait", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    m_req   = 1'b0;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    log_v = 1'b0;
    log_a = '0;
    @(negedge clk);
    chk("clr_err_valid", 32'(err_valid), 32'd0);
    chk("clr_err_addr", 32'(err_addr), 32'd0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 16'h4000 | AW'($urandom_range(0, 16'h1FFF));
      1:       return 16'h7000 | AW'($urandom_range(0, 16'h0FFF));
      2:       return AW'($urandom_range(0, 16'h3FFF));
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    m_req   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wen   = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_s_req", 32'(s_req), 32'd0);
    chk("rst_m_rdata", 32'(m_rdata), 32'd0);
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    chk("rst_s_wen", 32'(s_wen), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    do_txn(16'h4123, 1'b0, 16'h0000, 1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    do_txn(16'h7004, 1'b1, 16'h5A5A, 4, 16'h1234, 1'b0, 1'b0, 1'b1);
    do_txn(16'h0010, 1'b0, 16'h0000, 1, 16'h1111, 1'b0, 1'b0, 1'b0);
    pulse_clr();
    do_txn(16'h7000, 1'b0, 16'h0000, 255, 16'h2222, 1'b0, 1'b0, 1'b0);
    do_txn(16'h0020, 1'b0, 16'h0000, 1, 16'h3333, 1'b0, 1'b0, 1'b0);
    pulse_clr();
    do_txn(16'h4002, 1'b0, 16'h0000, TIMEOUT, 16'hC0DE, 1'b0, 1'b0, 1'b0);
    do_txn(16'h0040, 1'b0, 16'h0000, 1, 16'h0, 1'b0, 1'b0, 1'b0);
    do_txn(16'h0050, 1'b0, 16'h0000, 1, 16'h0, 1'b1, 1'b0, 1'b0);
    do_txn(16'h4800, 1'b0, 16'h0000, 2, 16'hA5A5, 1'b0, 1'b1, 1'b0);
    do_txn(16'h7FFE, 1'b1, 16'h0F0F, 1, 16'h0, 1'b0, 1'b1, 1'b0);
    do_txn(16'h9000, 1'b0, 16'h0000, 1, 16'h0, 1'b0, 1'b1, 1'b0);

    // Reset while a slave is being held in ACTIVE.
    @(posedge clk);
    #1;
    m_req = 1'b0;
    @(posedge clk);
    #1;
    slv_delay = 1000;
    exp_sel   = 2'b01;
    exp_addr  = 16'h4010;
    exp_wen   = 1'b0;
    m_req  = 1'b1;
    m_addr = 16'h4010;
    m_wen  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_s_req", 32'(s_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_s_req", 32'(s_req), 32'd0);
    m_req = 1'b0;
    sb.delete();
    log_v = 1'b0;
    log_a = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_m_ready", 32'(m_ready), 32'd0);
    chk("post_rst_s_req", 32'(s_req), 32'd0);
    do_txn(16'h5000, 1'b0, 16'h0000, 3, 16'h7777, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      int d;
      if ($urandom_range(0, 4) == 0) d = $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
      else d = $urandom_range(1, 5);
      do_txn(rand_addr(), 1'($urandom), DW'($urandom), d, DW'($urandom),
             ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom));
    end

    @(posedge clk);
    #1;
    m_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
